load_store_unit: RTL and testbench

Sits between the CPU execute stage and the word-organised data memory. Converts byte, halfword and word load/store requests into word-aligned accesses on the memory's chip-select/read/write/address/data port. The memory reads combinationally and writes on the clock edge. Sub-word stores are done as read-modify-write sequences, and loads are extracted and extended to 32 bits. Misaligned or illegal requests are flagged without any memory access.

---
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: turns byte/half/word load and store requests into
// word-aligned accesses on a combinational-read, edge-write data memory.
// Sub-word stores are done as read-modify-write. Loads are lane-extracted
// and sign/zero extended. Misaligned or illegal sizes fault without
// touching memory.
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic [31:0] rdata,
  output logic        dm_cs,
  output logic        dm_r,
  output logic        dm_w,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state, state_nx;
  logic        we_q, sext_q, fault_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q;
  logic        bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val, merged;

  // Fault decode on the live request: illegal size or misaligned half/word.
  always_comb begin
    bad = (size == 2'b11) ||
          (size == 2'b01 && addr[0]) ||
          (size == 2'b10 && addr[1:0] != 2'b00);
  end

  // Next-state and status/strobe outputs. Strobes are gated by reset so an
  // aborted WR never writes at the reset edge.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (req) begin
        if (bad)                       state_nx = DONE;
        else if (!we || size != 2'b10) state_nx = RD;
        else                           state_nx = WR;
      end
      RD:      state_nx = we_q ? WR : DONE;
      WR:      state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    busy     = (state == RD) || (state == WR);
    done     = (state == DONE);
    misalign = (state == DONE) && fault_q;
    dm_cs    = reset && ((state == RD) || (state == WR));
    dm_r     = reset && (state == RD);
    dm_w     = reset && (state == WR);
    dm_addr  = {addr_q[31:2], 2'b00};
  end

  // Load lane extraction straight from the memory read data during RD.
  always_comb begin
    byte_sel = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = dm_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_val = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_val = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_val = dm_rdata;
    endcase
  end

  // Store merge: replace the addressed lane(s) of the word read in RD.
  always_comb begin
    merged = word_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
    dm_wdata = merged;
  end

  // State register, request latch, read-word capture and load result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      fault_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req) begin
        we_q    <= we;
        sext_q  <= sign_ext;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
        fault_q <= bad;
      end
      if (state == RD) begin
        word_q <= dm_rdata;
        if (!we_q) rdata <= load_val;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a behavioural word memory, directed
// transactions with hand-computed expectations, and a monitor that checks
// each done pulse against the queued expectation.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, misalign, dm_cs, dm_r, dm_w;
  logic [31:0] rdata, dm_addr, dm_wdata, dm_rdata;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          nr;
    int          nw;
    logic [31:0] wa;
    logic [31:0] wd;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mem [256];
  int          cyc = 0, acc = 0, n_done = 0;
  int          nr = 0, nw = 0, nc = 0;
  logic [31:0] wa_seen = '0, wd_seen = '0;
  int          checks = 0, errors = 0;

  load_store_unit dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .misalign(misalign), .rdata(rdata), .dm_cs(dm_cs),
    .dm_r(dm_r), .dm_w(dm_w), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: combinational read, write at the clock edge.
  assign dm_rdata = mem[dm_addr[9:2]];
  always @(posedge clk) if (dm_cs && dm_w) mem[dm_addr[9:2]] <= dm_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: counts strobes, and checks each done pulse against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (dm_cs) nc++;
    if (dm_cs && dm_r) nr++;
    if (dm_cs && dm_w) begin
      nw++;
      wa_seen = dm_addr;
      wd_seen = dm_wdata;
    end
    if (done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        e = sbq.pop_front();
        chk("rdata", rdata, e.rd);
        chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
        chk("latency", cyc - acc, e.lat);
        chk("rd_strobes", nr, e.nr);
        chk("wr_strobes", nw, e.nw);
        chk("cs_cycles", nc, e.nr + e.nw);
        if (e.nw > 0) begin
          chk("wr_addr", wa_seen, e.wa);
          chk("wr_data", wd_seen, e.wd);
        end
      end
      n_done++;
    end
  end

  function automatic exp_t mk(input logic [31:0] rd, input logic mis, input int lat,
                              input int r, input int w, input logic [31:0] a,
                              input logic [31:0] d);
    exp_t e;
    e.rd = rd; e.mis = mis; e.lat = lat; e.nr = r; e.nw = w; e.wa = a; e.wd = d;
    return e;
  endfunction

  task automatic drive(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    we = w; size = sz; sign_ext = sx; addr = a; wdata = d; req = 1'b1;
    acc = cyc; nr = 0; nw = 0; nc = 0;
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  // Issue one request and wait (bounded) for its done pulse.
  task automatic xfer(input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] d, input exp_t e);
    int prev;
    prev = n_done;
    sbq.push_back(e);
    drive(w, sz, sx, a, d);
    for (int i = 0; i < 8 && n_done == prev; i++) @(posedge clk);
    if (n_done == prev) begin
      checks++;
      errors++;
      $display("FAIL timeout: got no done expected done for addr %h", a);
      sbq.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},     {31'b0, busy},     32'h0);
    chk({tag, "_done"},     {31'b0, done},     32'h0);
    chk({tag, "_misalign"}, {31'b0, misalign}, 32'h0);
    chk({tag, "_cs_r_w"},   {29'b0, dm_cs, dm_r, dm_w}, 32'h0);
    chk({tag, "_rdata"},    rdata,    32'h0);
    chk({tag, "_dm_addr"},  dm_addr,  32'h0);
    chk({tag, "_dm_wdata"}, dm_wdata, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[64] = 32'h8899AABB;
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("reset");
    reset = 1'b1;

    // Loads from 0x100 = 8899AABB
    xfer(0, 2'b00, 1, 32'h103, 0, mk(32'hFFFFFF88, 0, 2, 1, 0, 0, 0));
    xfer(0, 2'b01, 0, 32'h102, 0, mk(32'h00008899, 0, 2, 1, 0, 0, 0));
    xfer(0, 2'b01, 1, 32'h102, 0, mk(32'hFFFF8899, 0, 2, 1, 0, 0, 0));
    xfer(0, 2'b01, 1, 32'h100, 0, mk(32'hFFFFAABB, 0, 2, 1, 0, 0, 0));
    xfer(0, 2'b00, 0, 32'h100, 0, mk(32'h000000BB, 0, 2, 1, 0, 0, 0));
    xfer(0, 2'b10, 1, 32'h100, 0, mk(32'h8899AABB, 0, 2, 1, 0, 0, 0));
    // Stores leave rdata alone
    xfer(1, 2'b00, 0, 32'h101, 32'h12345677, mk(32'h8899AABB, 0, 3, 1, 1, 32'h100, 32'h889977BB));
    xfer(1, 2'b10, 0, 32'h104, 32'hDEADBEEF, mk(32'h8899AABB, 0, 2, 0, 1, 32'h104, 32'hDEADBEEF));
    // Faults: no strobes, rdata unchanged
    xfer(1, 2'b01, 0, 32'h101, 32'h0000FFFF, mk(32'h8899AABB, 1, 1, 0, 0, 0, 0));
    xfer(0, 2'b10, 0, 32'h102, 0, mk(32'h8899AABB, 1, 1, 0, 0, 0, 0));
    xfer(0, 2'b11, 0, 32'h100, 0, mk(32'h8899AABB, 1, 1, 0, 0, 0, 0));
    chk("mem_after_faults", mem[64], 32'h889977BB);
    // More sub-word traffic
    xfer(1, 2'b01, 0, 32'h102, 32'hCAFE1234, mk(32'h8899AABB, 0, 3, 1, 1, 32'h100, 32'h123477BB));
    xfer(0, 2'b00, 1, 32'h101, 0, mk(32'h00000077, 0, 2, 1, 0, 0, 0));
    xfer(0, 2'b10, 0, 32'h104, 0, mk(32'hDEADBEEF, 0, 2, 1, 0, 0, 0));
    xfer(1, 2'b00, 0, 32'h107, 32'h000000AB, mk(32'hDEADBEEF, 0, 3, 1, 1, 32'h104, 32'hABADBEEF));
    chk("mem_0x100", mem[64], 32'h123477BB);
    chk("mem_0x104", mem[65], 32'hABADBEEF);

    // Abort a byte store in its WR cycle: no write, no done.
    drive(1, 2'b00, 0, 32'h100, 32'h00000055);  // now in RD
    @(posedge clk); #1;                          // now in WR
    chk("abort_in_wr_busy", {31'b0, busy}, 32'h1);
    reset = 1'b0;
    #1 chk("abort_dm_w_gated", {31'b0, dm_w}, 32'h0);
    @(posedge clk); #1;
    chk_reset_outputs("abort");
    chk("abort_mem", mem[64], 32'h123477BB);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    xfer(0, 2'b10, 0, 32'h100, 0, mk(32'h123477BB, 0, 2, 1, 0, 0, 0));
    repeat (2) @(posedge clk);
    chk("scoreboard_empty", sbq.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
